pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB). It detects load-use hazards and stalls with a single bubble, and flushes wrong-path instructions on a taken branch or jump resolved in EX. It also recognises the halt word in ID and drains the pipeline before signalling completion. It drives the write enables of the PC and IF/ID registers and the bubble/flush controls of IF/ID and ID/EX in `CPU`.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states, the
// opcodes whose rt field is a source operand, and the default halt word.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        STALL = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_SW    = 6'h2B;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    function automatic logic rt_is_source(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in ID/EX and the
// source registers of the instruction in IF/ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:16] id_instr,
    input  logic         id_valid,
    input  logic         ex_mem_read,
    input  logic [4:0]   ex_rt,
    output logic         load_use
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_hit;
    logic       rt_hit;

    assign opcode = id_instr[31:26];
    assign rs     = id_instr[25:21];
    assign rt     = id_instr[20:16];

    assign rs_hit = (ex_rt == rs);
    assign rt_hit = rt_is_source(opcode) && (ex_rt == rt);

    // $zero is never a real dependency, so a load to r0 cannot stall.
    assign load_use = id_valid && ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, halt drain.
// Optional performance counters are enabled with PIPE_HAZARD_CTRL_PERF_EN.
//
// state | meaning
// RUN   | normal issue; hazards, branches and halt are evaluated
// STALL | one-cycle bubble after a load-use hazard
// FLUSH | one cycle after a taken branch; IF/ID contents ignored
// DRAIN | halt seen; freeze front end while older instructions retire
// DONE  | pipeline drained; terminal until reset
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        done,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [2:0]  state
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             halt_seen;
    logic             stall_evt;
    logic             flush_evt;

    hazard_detect u_hazard_detect (
        .id_instr    (id_instr[31:16]),
        .id_valid    (id_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    assign halt_seen = id_valid && (id_instr == HALT_WORD);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        done         = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        unique case (state_q)
            RUN: begin
                // A taken branch makes the ID instruction wrong-path, so it wins.
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_evt   = 1'b1;
                    state_d     = FLUSH;
                end else if (halt_seen) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = DRAIN;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_evt    = 1'b1;
                    state_d      = STALL;
                end
            end
            STALL: begin
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_evt   = 1'b1;
                    state_d     = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                done         = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset holds the front end cleared regardless of registered state.
        if (!RESET) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            done         = 1'b0;
            stall_evt    = 1'b0;
            flush_evt    = 1'b0;
        end
    end

    assign state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q != DONE) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (stall_evt)       stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt)       flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed
// outputs per cycle, the monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, done;
    logic [2:0]  state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.DRAIN_CYCLES(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .id_instr        (id_instr),
        .id_valid        (id_valid),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .done            (done),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .cycle_cnt       (cycle_cnt),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .state           (state)
    );

    always #5 CLK = ~CLK;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, done}
    localparam logic [5:0] O_DEF = 6'b110000;
    localparam logic [5:0] O_FRZ = 6'b001000;
    localparam logic [5:0] O_FLS = 6'b110110;
    localparam logic [5:0] O_RST = 6'b000110;
    localparam logic [5:0] O_DN  = 6'b001001;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] ADD  = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] ADDI = 32'h2043_0005; // addi $3,$2,5
    localparam logic [31:0] SW   = 32'hAC25_0000; // sw $5,0($1)
    localparam logic [31:0] BEQ  = 32'h1025_0000; // beq $1,$5
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [5:0] outs;
        logic [2:0] st;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic drive(input string nm, input logic rst, input logic [31:0] instr,
                         input logic vld, input logic mr, input logic [4:0] rt,
                         input logic br, input logic [5:0] outs, input logic [2:0] st);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET           = rst;
        id_instr        = instr;
        id_valid        = vld;
        ex_mem_read     = mr;
        ex_rt           = rt;
        ex_branch_taken = br;
        e.outs = outs;
        e.st   = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [5:0] act;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, done};
            n_vec++;
            if (act !== e.outs || state !== e.st) begin
                n_miss++;
                $display("FAIL %s: got outs=%b state=%0d, want outs=%b state=%0d",
                         nm, act, state, e.outs, e.st);
            end
        end
    end

    initial begin
        RESET = 1'b0; id_instr = NOP; id_valid = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;

        for (int i = 0; i < 3; i++)
            drive("reset_hold", 1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, O_RST, 3'd0);
        drive("reset_release", 1'b1, NOP, 1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);

        drive("lu_rs",          1'b1, ADD,  1'b1, 1'b1, 5'd2, 1'b0, O_FRZ, 3'd0);
        drive("lu_rs_stall",    1'b1, ADD,  1'b1, 1'b1, 5'd2, 1'b0, O_DEF, 3'd1);
        drive("lu_after",       1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);
        drive("no_lu_r0",       1'b1, ADD,  1'b1, 1'b1, 5'd0, 1'b0, O_DEF, 3'd0);
        drive("no_lu_addi_4",   1'b1, ADDI, 1'b1, 1'b1, 5'd4, 1'b0, O_DEF, 3'd0);
        drive("no_lu_addi_rt",  1'b1, ADDI, 1'b1, 1'b1, 5'd3, 1'b0, O_DEF, 3'd0);
        drive("lu_rtype_rt",    1'b1, ADD,  1'b1, 1'b1, 5'd4, 1'b0, O_FRZ, 3'd0);
        drive("lu_rtype_stall", 1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd1);
        drive("lu_sw_rt",       1'b1, SW,   1'b1, 1'b1, 5'd5, 1'b0, O_FRZ, 3'd0);
        drive("lu_sw_stall",    1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd1);
        drive("no_lu_invalid",  1'b1, ADD,  1'b0, 1'b1, 5'd2, 1'b0, O_DEF, 3'd0);

        drive("br_over_lu",     1'b1, ADD,  1'b1, 1'b1, 5'd2, 1'b1, O_FLS, 3'd0);
        drive("flush_ignores",  1'b1, ADD,  1'b1, 1'b1, 5'd2, 1'b0, O_DEF, 3'd2);
        drive("after_flush",    1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);

        drive("lu_beq_rt",      1'b1, BEQ,  1'b1, 1'b1, 5'd5, 1'b0, O_FRZ, 3'd0);
        drive("br_in_stall",    1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b1, O_FLS, 3'd1);
        drive("flush_2",        1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd2);
        drive("run_2",          1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);

        drive("br_over_halt",   1'b1, HALT, 1'b1, 1'b0, 5'd0, 1'b1, O_FLS, 3'd0);
        drive("flush_3",        1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd2);
        drive("run_3",          1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);

        drive("halt_seen",      1'b1, HALT, 1'b1, 1'b0, 5'd0, 1'b0, O_FRZ, 3'd0);
        for (int i = 0; i < 4; i++)
            drive("drain", 1'b1, NOP, 1'b1, 1'b0, 5'd0, 1'b1, O_FRZ, 3'd3);
        for (int i = 0; i < 3; i++)
            drive("done_held", 1'b1, NOP, 1'b1, 1'b0, 5'd0, 1'b1, O_DN, 3'd4);

        drive("reset_from_done", 1'b0, NOP,  1'b0, 1'b0, 5'd0, 1'b0, O_RST, 3'd0);
        drive("halt_again",      1'b1, HALT, 1'b1, 1'b0, 5'd0, 1'b0, O_FRZ, 3'd0);
        drive("drain_1",         1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_FRZ, 3'd3);
        drive("reset_mid_drain", 1'b0, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_RST, 3'd0);
        drive("run_after_rst",   1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd0);
        drive("lu_after_rst",    1'b1, ADD,  1'b1, 1'b1, 5'd2, 1'b0, O_FRZ, 3'd0);
        drive("stall_after_rst", 1'b1, NOP,  1'b1, 1'b0, 5'd0, 1'b0, O_DEF, 3'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        // Counters were cleared by the mid-drain reset; one stall since then.
        n_vec++;
        if (stall_cnt !== 32'd1) begin
            n_miss++;
            $display("FAIL stall_cnt: got %0d, want 1", stall_cnt);
        end
        n_vec++;
        if (flush_cnt !== 32'd0) begin
            n_miss++;
            $display("FAIL flush_cnt: got %0d, want 0", flush_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
